// File: rtl/kernel_invoke_ctrl.sv
// Sequences one Dynamatic kernel run per tagged command and queues {out0, tag, cycles, timeout} results.
// ap_start rises 1 cycle after command accept; cmd_ready is withheld while busy or the result FIFO is full.
module kernel_invoke_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TAG_WIDTH      = 4,
  parameter int CYCLE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int KRST_CYCLES    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TAG_WIDTH-1:0]   cmd_tag,
  output logic                   kernel_rst,
  output logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic [DATA_WIDTH-1:0]  kernel_out0,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic [TAG_WIDTH-1:0]   res_tag,
  output logic [CYCLE_WIDTH-1:0] res_cycles,
  output logic                   res_timeout,
  output logic                   busy
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int KW   = (KRST_CYCLES > 1) ? $clog2(KRST_CYCLES + 1) : 1;
  localparam logic [CYCLE_WIDTH-1:0] TO_VAL    = CYCLE_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0]        DEPTH_VAL = CNTW'(FIFO_DEPTH);
  localparam logic [KW-1:0]          KRST_LAST = KW'(KRST_CYCLES - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [TAG_WIDTH-1:0]   tag;
    logic [CYCLE_WIDTH-1:0] cycles;
    logic                   timeout;
  } res_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_ABORT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [CYCLE_WIDTH-1:0] r_cnt;
  logic [KW-1:0]          r_krst_cnt;
  res_t                   r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]        r_count;

  logic                   w_full, w_push, w_pop, w_accept_cmd, w_accept_start;
  logic                   w_done, w_timeout_hit, w_krst_last;
  logic [CYCLE_WIDTH-1:0] w_cnt_inc;
  res_t                   w_push_entry;

  assign w_full         = (r_count == DEPTH_VAL);
  assign w_accept_cmd   = cmd_valid && cmd_ready;
  assign w_accept_start = (r_state == S_START) && ap_ready && !rst;
  assign w_cnt_inc      = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_done         = (r_state == S_RUN) && ap_done;
  // Done takes priority over a timeout landing in the same cycle.
  assign w_timeout_hit  = (r_state == S_RUN) && !ap_done && (w_cnt_inc >= TO_VAL);
  assign w_krst_last    = (r_krst_cnt == KRST_LAST);
  assign w_pop          = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept_cmd) w_state_nxt = S_START;
      S_START: if (ap_ready) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_done)             w_state_nxt = S_IDLE;
        else if (w_timeout_hit) w_state_nxt = S_ABORT;
      end
      S_ABORT: if (w_krst_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (r_state == S_IDLE) && !w_full && !rst;
    ap_start     = (r_state == S_START) && !rst;
    busy         = (r_state != S_IDLE);
    kernel_rst   = rst || (r_state == S_ABORT);
    w_push       = (w_done || w_timeout_hit) && !w_full;
    w_push_entry = '0;
    w_push_entry.tag = r_tag;
    if (w_done) begin
      w_push_entry.data   = kernel_out0;
      w_push_entry.cycles = w_cnt_inc;
    end else begin
      w_push_entry.cycles  = TO_VAL;
      w_push_entry.timeout = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= '0;
      r_cnt      <= '0;
      r_krst_cnt <= '0;
    end else begin
      if (w_accept_cmd) r_tag <= cmd_tag;
      if (w_accept_start)          r_cnt <= '0;
      else if (r_state == S_RUN)   r_cnt <= w_cnt_inc;
      if (r_state == S_ABORT) r_krst_cnt <= r_krst_cnt + 1'b1;
      else                    r_krst_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign res_valid   = (r_count != '0);
  assign res_data    = r_mem[r_rd_ptr].data;
  assign res_tag     = r_mem[r_rd_ptr].tag;
  assign res_cycles  = r_mem[r_rd_ptr].cycles;
  assign res_timeout = r_mem[r_rd_ptr].timeout;

endmodule

// File: tb/tb_kernel_invoke_ctrl.sv
// Randomised bench for kernel_invoke_ctrl: a behavioural kernel plus a result scoreboard.
module tb_kernel_invoke_ctrl;
  localparam int DW = 8, TW = 4, CW = 32, TO = 20, KR = 2, FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, kernel_rst, ap_start, ap_ready, ap_done;
  logic [TW-1:0] cmd_tag, res_tag;
  logic [DW-1:0] kernel_out0, res_data;
  logic          res_valid, res_ready, res_timeout, busy;
  logic [CW-1:0] res_cycles;

  kernel_invoke_ctrl #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CYCLE_WIDTH(CW),
    .TIMEOUT_CYCLES(TO), .KRST_CYCLES(KR), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
    .kernel_rst(kernel_rst), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .kernel_out0(kernel_out0), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_cycles(res_cycles),
    .res_timeout(res_timeout), .busy(busy)
  );

  typedef struct {int rd; int d; logic [DW-1:0] out0;} plan_t;
  typedef struct {logic [DW-1:0] data; logic [TW-1:0] tag; logic [CW-1:0] cycles; logic to;} exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0, failures = 0;
  int    exp_pulses = 0, seen_pulses = 0;
  bit    rr_rand = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Kernel: ap_ready low for rd cycles after ap_start appears, done d cycles after acceptance.
  plan_t kp;
  int    held;
  bit    aborted;
  initial begin
    ap_ready = 1'b0; ap_done = 1'b0; kernel_out0 = '0;
    forever begin
      @(posedge clk); #1;
      if (ap_start && !rst) begin
        if (plan_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          kp = plan_q.pop_front();
          held = 1;
          for (int i = 0; i < kp.rd; i++) begin
            @(posedge clk); #1;
            if (ap_start) held++;
          end
          ap_ready = 1'b1;
          @(posedge clk); #1;
          ap_ready = 1'b0;
          check("ap_start_held", held, kp.rd + 1);
          check("ap_start_drop", ap_start, 0);
          aborted = 1'b0;
          for (int k = 1; k < kp.d; k++) begin
            if (rst) begin aborted = 1'b1; break; end
            @(posedge clk); #1;
          end
          if (!aborted && !rst) begin
            ap_done = 1'b1; kernel_out0 = kp.out0;
            @(posedge clk); #1;
            ap_done = 1'b0; kernel_out0 = DW'($urandom);
            if (kp.d <= TO) check("res_valid_after_done", res_valid, 1);
          end
        end
      end
    end
  end

  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          me = exp_q.pop_front();
          check("res_tag", res_tag, me.tag);
          check("res_data", res_data, me.data);
          check("res_cycles", res_cycles, me.cycles);
          check("res_timeout", res_timeout, me.to);
        end
      end
    end
  end

  int krun = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) krun = 0;
      else if (kernel_rst) krun++;
      else if (krun > 0) begin
        check("kernel_rst_pulse_len", krun, KR);
        seen_pulses++;
        krun = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [TW-1:0] tag, input int rd, input int d,
                       input logic [DW-1:0] out0, input bit expect_res);
    plan_t p;
    exp_t  e;
    int    n;
    p.rd = rd; p.d = d; p.out0 = out0;
    n = 0;
    cmd_valid = 1'b1; cmd_tag = tag;
    while (!cmd_ready && n < 300) begin wait_cycles(1); n++; end
    if (n >= 300) begin
      check("cmd_ready_wait", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    plan_q.push_back(p);
    if (expect_res) begin
      e.tag = tag;
      if (d <= TO) begin e.data = out0; e.cycles = CW'(d); e.to = 1'b0; end
      else begin e.data = '0; e.cycles = CW'(TO); e.to = 1'b1; exp_pulses++; end
      exp_q.push_back(e);
    end
    wait_cycles(1);
    cmd_valid = 1'b0; cmd_tag = TW'($urandom);
    check("ap_start_latency", ap_start, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || plan_q.size() != 0) && n < 500) begin wait_cycles(1); n++; end
    if (n >= 500) check("idle_wait", 0, 1);
    wait_cycles(3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin wait_cycles(1); n++; end
    if (n >= 2000) check("drain_wait", 0, 1);
    wait_cycles(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int r, dd;
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_tag = '0; res_ready = 1'b0;
    wait_cycles(3);
    check("rst_kernel_rst", kernel_rst, 1);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cycles(1);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_kernel_rst", kernel_rst, 0);

    res_ready = 1'b1;
    issue(4'd3, 0, 10, 8'h5A, 1'b1);
    drain();
    issue(4'd5, 4, 7, 8'hC3, 1'b1);
    drain();

    issue(4'd9, 0, TO + 1, 8'h11, 1'b1);
    drain();
    issue(4'd10, 1, 3, 8'h22, 1'b1);
    issue(4'd12, 2, TO + 2, 8'h33, 1'b1);
    issue(4'd11, 0, TO, 8'h44, 1'b1);
    drain();
    check("pulses_after_timeouts", seen_pulses, exp_pulses);

    res_ready = 1'b0;
    for (int i = 0; i < FD; i++) issue(TW'(i), 0, 2 + i, 8'(8'h80 + i), 1'b1);
    wait_idle();
    check("full_cmd_ready", cmd_ready, 0);
    check("full_res_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_cycles(1);
    res_ready = 1'b0;
    check("after_pop_cmd_ready", cmd_ready, 1);
    issue(4'd4, 0, 1, 8'h95, 1'b1);
    wait_idle();
    check("refull_cmd_ready", cmd_ready, 0);
    res_ready = 1'b1;
    wait_cycles(1);
    res_ready = 1'b0;
    issue(4'd6, 0, 1, 8'h96, 1'b1);
    wait_cycles(1);
    res_ready = 1'b1;
    wait_cycles(1);
    res_ready = 1'b0;
    wait_idle();
    check("push_pop_cmd_ready", cmd_ready, 1);
    issue(4'd7, 0, 1, 8'h97, 1'b1);
    wait_idle();
    check("push_pop_full", cmd_ready, 0);
    res_ready = 1'b1;
    drain();

    issue(4'd13, 0, 1000, 8'h00, 1'b0);
    wait_cycles(8);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_kernel_rst", kernel_rst, 1);
    check("midrst_ap_start", ap_start, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(3);
    check("postrst_busy", busy, 0);
    check("postrst_res_valid", res_valid, 0);
    issue(4'd14, 0, 4, 8'h3C, 1'b1);
    drain();

    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      dd = int'($urandom_range(1, 12));
      else if (r < 8) dd = TO;
      else            dd = int'($urandom_range(TO + 1, TO + 2));
      issue(TW'($urandom), int'($urandom_range(0, 3)), dd, DW'($urandom), 1'b1);
      wait_cycles(int'($urandom_range(0, 3)));
    end
    rr_rand = 1'b0;
    wait_cycles(1);
    res_ready = 1'b1;
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    check("plans_consumed", plan_q.size(), 0);
    check("abort_pulses", seen_pulses, exp_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
